// File: rtl/shift_rows_stream.sv
// Byte-serial AES ShiftRows with two ping-pong 16-byte block buffers.
// One buffer fills while the other drains, giving one byte per clock.
module shift_rows_stream (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_last
);

   logic [1:0] full_q, full_d;
   logic       wr_sel_q, wr_sel_d;
   logic       rd_sel_q, rd_sel_d;
   logic [3:0] wr_cnt_q, wr_cnt_d;
   logic [3:0] rd_cnt_q, rd_cnt_d;
   logic [7:0] mem_q [2][16];
   logic       wr_fire;
   logic       rd_fire;
   logic [1:0] src_col;
   logic [3:0] src_idx;

   assign in_ready  = !full_q[wr_sel_q];
   assign out_valid = full_q[rd_sel_q];
   assign wr_fire   = in_valid && in_ready && !clr;
   assign rd_fire   = out_valid && out_ready && !clr;

   // rd_cnt = 4c+r; the 2-bit add wraps the source column mod 4
   assign src_col  = rd_cnt_q[3:2] + rd_cnt_q[1:0];
   assign src_idx  = {src_col, rd_cnt_q[1:0]};
   assign out_data = out_valid ? mem_q[rd_sel_q][src_idx] : 8'h00;
   assign out_last = out_valid && (rd_cnt_q == 4'd15);

   always_comb begin
      full_d   = full_q;
      wr_sel_d = wr_sel_q;
      rd_sel_d = rd_sel_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      if (clr) begin
         full_d   = 2'b00;
         wr_sel_d = 1'b0;
         rd_sel_d = 1'b0;
         wr_cnt_d = 4'd0;
         rd_cnt_d = 4'd0;
      end else begin
         if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 4'd1;
            if (wr_cnt_q == 4'd15) begin
               full_d[wr_sel_q] = 1'b1;
               wr_sel_d         = !wr_sel_q;
            end
         end
         // never the same buffer as the write side when it completes
         if (rd_fire) begin
            rd_cnt_d = rd_cnt_q + 4'd1;
            if (rd_cnt_q == 4'd15) begin
               full_d[rd_sel_q] = 1'b0;
               rd_sel_d         = !rd_sel_q;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q   <= 2'b00;
         wr_sel_q <= 1'b0;
         rd_sel_q <= 1'b0;
         wr_cnt_q <= 4'd0;
         rd_cnt_q <= 4'd0;
      end else begin
         full_q   <= full_d;
         wr_sel_q <= wr_sel_d;
         rd_sel_q <= rd_sel_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   // Block storage carries no reset; only the control state is cleared
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem_q[wr_sel_q][wr_cnt_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Scoreboard bench for shift_rows_stream: driver feeds a block-level
// reference model, a separate monitor pops and compares every output beat.
module tb_shift_rows_stream;

   logic       clk;
   logic       rst;
   logic       clr;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;

   int n_cmp;
   int n_err;
   int stalls;
   int cyc;

   logic [7:0] in_q[$];
   logic [8:0] exp_q[$];
   logic [7:0] got_q[$];
   int         got_cyc[$];

   shift_rows_stream dut (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_last(out_last)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: out[4c+r] = in[4((c+r) mod 4)+r], computed per whole block
   task automatic model_push(input logic [7:0] b);
      int c;
      int r;
      in_q.push_back(b);
      if (in_q.size() == 16) begin
         for (int n = 0; n < 16; n++) begin
            c = n / 4;
            r = n % 4;
            exp_q.push_back({n == 15, in_q[4 * ((c + r) % 4) + r]});
         end
         in_q.delete();
      end
   endtask

   // Monitor: sample mid-cycle; a beat seen here completes at the next edge
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (!rst && !clr && out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("unexpected_beat", {23'd0, out_last, out_data}, 32'hfff);
            end else begin
               e = exp_q.pop_front();
               check("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
               check("out_last", {31'd0, out_last}, {31'd0, e[8]});
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int w;
      w = 0;
      in_valid = 1'b1;
      in_data  = b;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         stalls++;
         w++;
         if (w > 300) begin
            check("in_timeout", 32'd1, 32'd0);
            break;
         end
      end
      if (in_ready) model_push(b);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_block(input logic [127:0] blk);
      for (int i = 0; i < 16; i++) send_byte(blk[127 - 8 * i -: 8]);
   endtask

   task automatic send_rand_block();
      for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(0, 255)));
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 400) begin
         @(posedge clk);
         w++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_got(input string name, input logic [127:0] v);
      check({name, "_count"}, got_q.size(), 32'd16);
      for (int i = 0; i < 16 && i < got_q.size(); i++)
         check(name, {24'd0, got_q[i]}, {24'd0, v[127 - 8 * i -: 8]});
   endtask

   logic [127:0] id_in;
   logic [127:0] id_out;
   logic [127:0] fips_in;
   logic [127:0] fips_out;

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      stalls    = 0;
      cyc       = 0;
      rst       = 1'b1;
      clr       = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      id_in     = 128'h000102030405060708090a0b0c0d0e0f;
      id_out    = 128'h00050a0f04090e03080d02070c01060b;
      fips_in   = 128'hd42711aee0bf98f1b8b45de51e415230;
      fips_out  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

      #12;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check("rst_out_last", {31'd0, out_last}, 32'd0);
      #11;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Identity vector and latency
      out_ready = 1'b1;
      got_q.delete();
      for (int i = 0; i < 15; i++) send_byte(id_in[127 - 8 * i -: 8]);
      check("lat_before", {31'd0, out_valid}, 32'd0);
      send_byte(id_in[7:0]);
      check("lat_after", {31'd0, out_valid}, 32'd1);
      check("lat_byte0", {24'd0, out_data}, 32'h00);
      wait_drain();
      check_got("identity", id_out);

      // FIPS-197 round 1 ShiftRows
      got_q.delete();
      send_block(fips_in);
      wait_drain();
      check_got("fips", fips_out);

      // Streaming, four back-to-back blocks
      got_q.delete();
      got_cyc.delete();
      stalls = 0;
      for (int b = 0; b < 4; b++) send_rand_block();
      wait_drain();
      check("stream_stalls", stalls, 32'd0);
      check("stream_count", got_q.size(), 32'd64);
      if (got_cyc.size() == 64)
         check("stream_bubbles", got_cyc[63] - got_cyc[0], 32'd63);

      // Backpressure, two blocks with out_ready low
      out_ready = 1'b0;
      got_q.delete();
      send_block(id_in);
      send_rand_block();
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("bp_hold_data", {24'd0, out_data}, 32'h00);
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      wait_drain();
      check("bp_count", got_q.size(), 32'd32);

      // Abort: partial block, clr with a handshake in the same cycle
      got_q.delete();
      for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(0, 255)));
      clr      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hee;
      @(posedge clk);
      #1;
      clr      = 1'b0;
      in_valid = 1'b0;
      in_q.delete();
      exp_q.delete();
      check("clr_in_ready", {31'd0, in_ready}, 32'd1);
      check("clr_out_valid", {31'd0, out_valid}, 32'd0);
      send_block(id_in);
      wait_drain();
      check_got("abort", id_out);

      // Async reset while presenting output byte 9
      out_ready = 1'b0;
      send_block(id_in);
      out_ready = 1'b1;
      repeat (9) @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("pre_rst_byte9", {24'd0, out_data}, 32'h0d);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_out_data", {24'd0, out_data}, 32'h00);
      check("arst_in_ready", {31'd0, in_ready}, 32'd1);
      in_q.delete();
      exp_q.delete();
      #10;
      rst = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      got_q.delete();
      send_block(fips_in);
      wait_drain();
      check_got("post_rst", fips_out);

      check("final_queue", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
